// File: rtl/vram_arbiter.sv
// VRAM port arbiter: the video engine owns non-blit cycles, and blit slots are shared round-robin by host A, host B and the blitter.
// Optional feature VRAM_ARB_HOST_PRIORITY_EN: A/B round-robin between themselves, and the blitter only gets otherwise idle slots.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              blit_cycle_i,
    input  logic              vid_sel_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    input  logic              a_req_i,
    input  logic              a_wr_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic              b_req_i,
    input  logic              b_wr_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    input  logic              bl_req_i,
    input  logic              bl_wr_i,
    input  logic [ADDR_W-1:0] bl_addr_i,
    input  logic [DATA_W-1:0] bl_wdata_i,
    output logic              a_ack_o,
    output logic              b_ack_o,
    output logic              bl_ack_o,
    output logic              a_rvalid_o,
    output logic              b_rvalid_o,
    output logic              bl_rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_wdata_o,
    input  logic [DATA_W-1:0] vram_rdata_i,
    output logic              vid_conflict_o
);

    localparam logic [1:0] PTR_A  = 2'd0;
    localparam logic [1:0] PTR_B  = 2'd1;
    localparam logic [1:0] PTR_BL = 2'd2;

    logic [2:0]        req;
    logic [2:0]        wr;
    logic [2:0]        elig;
    logic [2:0]        grant;
    logic [2:0]        ack_q;
    logic [2:0]        rd_q;
    logic [2:0]        rvalid_q;
    logic [1:0]        rr_ptr;
    logic [1:0]        rr_next;
    logic [DATA_W-1:0] rdata_q;
    logic              conflict_q;

    assign req  = {bl_req_i, b_req_i, a_req_i};
    assign wr   = {bl_wr_i, b_wr_i, a_wr_i};
    // A request is masked for the cycle its ack is showing, so a held req is not granted twice.
    assign elig = req & ~ack_q;

    always_comb begin
        grant   = 3'b000;
        rr_next = rr_ptr;
        if (blit_cycle_i) begin
`ifdef VRAM_ARB_HOST_PRIORITY_EN
            if (rr_ptr == PTR_B) begin
                if (elig[1])      grant = 3'b010;
                else if (elig[0]) grant = 3'b001;
            end else begin
                if (elig[0])      grant = 3'b001;
                else if (elig[1]) grant = 3'b010;
            end
            if (grant == 3'b000 && elig[2]) grant = 3'b100;
            if (grant[0])      rr_next = PTR_B;
            else if (grant[1]) rr_next = PTR_A;
`else
            case (rr_ptr)
                PTR_B: begin
                    if (elig[1])      grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                end
                PTR_BL: begin
                    if (elig[2])      grant = 3'b100;
                    else if (elig[0]) grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                end
                default: begin
                    if (elig[0])      grant = 3'b001;
                    else if (elig[1]) grant = 3'b010;
                    else if (elig[2]) grant = 3'b100;
                end
            endcase
            if (grant[0])      rr_next = PTR_B;
            else if (grant[1]) rr_next = PTR_BL;
            else if (grant[2]) rr_next = PTR_A;
`endif
        end
    end

    always_comb begin
        vram_sel_o   = 1'b0;
        vram_wr_o    = 1'b0;
        vram_addr_o  = '0;
        vram_wdata_o = '0;
        if (reset_n_i) begin
            if (!blit_cycle_i) begin
                vram_sel_o  = vid_sel_i;
                vram_addr_o = vid_addr_i;
            end else if (grant[0]) begin
                vram_sel_o   = 1'b1;
                vram_wr_o    = a_wr_i;
                vram_addr_o  = a_addr_i;
                vram_wdata_o = a_wdata_i;
            end else if (grant[1]) begin
                vram_sel_o   = 1'b1;
                vram_wr_o    = b_wr_i;
                vram_addr_o  = b_addr_i;
                vram_wdata_o = b_wdata_i;
            end else if (grant[2]) begin
                vram_sel_o   = 1'b1;
                vram_wr_o    = bl_wr_i;
                vram_addr_o  = bl_addr_i;
                vram_wdata_o = bl_wdata_i;
            end
        end
    end

    // rd_q marks the cycle the BRAM output belongs to the granted read; rdata_q then holds it.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr     <= PTR_A;
            ack_q      <= 3'b000;
            rd_q       <= 3'b000;
            rvalid_q   <= 3'b000;
            rdata_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            rr_ptr     <= rr_next;
            ack_q      <= grant;
            rd_q       <= grant & ~wr;
            rvalid_q   <= rd_q;
            conflict_q <= blit_cycle_i & vid_sel_i;
            if (|rd_q) rdata_q <= vram_rdata_i;
        end
    end

    assign a_ack_o        = ack_q[0];
    assign b_ack_o        = ack_q[1];
    assign bl_ack_o       = ack_q[2];
    assign a_rvalid_o     = rvalid_q[0];
    assign b_rvalid_o     = rvalid_q[1];
    assign bl_rvalid_o    = rvalid_q[2];
    assign rdata_o        = rdata_q;
    assign vid_conflict_o = conflict_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a table of directed vectors, hand-written corner sequences and random traffic.
// Every check compares the DUT against an event-schedule reference model.
module tb_vram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        blit = 1'b0;
    logic        vid_sel = 1'b0;
    logic [15:0] vid_addr = '0;
    logic [2:0]  req = '0;
    logic [2:0]  wr = '0;
    logic [15:0] addr [3];
    logic [15:0] wdata [3];
    logic [15:0] vram_rdata = '0;

    logic        a_ack, b_ack, bl_ack, a_rv, b_rv, bl_rv;
    logic [15:0] rdata, vram_addr, vram_wdata;
    logic        vram_sel, vram_wr, conflict;

    vram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset_n_i(rst_n), .blit_cycle_i(blit),
        .vid_sel_i(vid_sel), .vid_addr_i(vid_addr),
        .a_req_i(req[0]), .a_wr_i(wr[0]), .a_addr_i(addr[0]), .a_wdata_i(wdata[0]),
        .b_req_i(req[1]), .b_wr_i(wr[1]), .b_addr_i(addr[1]), .b_wdata_i(wdata[1]),
        .bl_req_i(req[2]), .bl_wr_i(wr[2]), .bl_addr_i(addr[2]), .bl_wdata_i(wdata[2]),
        .a_ack_o(a_ack), .b_ack_o(b_ack), .bl_ack_o(bl_ack),
        .a_rvalid_o(a_rv), .b_rvalid_o(b_rv), .bl_rvalid_o(bl_rv),
        .rdata_o(rdata), .vram_sel_o(vram_sel), .vram_wr_o(vram_wr),
        .vram_addr_o(vram_addr), .vram_wdata_o(vram_wdata),
        .vram_rdata_i(vram_rdata), .vid_conflict_o(conflict)
    );

    function automatic logic [15:0] bram_f(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h3C3C;
    endfunction

    // BRAM with one cycle of read latency
    always @(posedge clk) vram_rdata <= bram_f(vram_addr);

    typedef struct {
        int          due;
        int          kind;
        int          port;
        logic [15:0] data;
    } ev_t;

    ev_t         evq[$];
    int          cyc = 0;
    int          m_ptr = 0;
    logic [15:0] m_last = '0;
    logic [2:0]  m_ack = '0;
    int          checks = 0;
    int          errors = 0;

    logic        smp_sel, smp_wr, smp_conf;
    logic [15:0] smp_addr, smp_wdata, smp_rdata;
    logic [2:0]  smp_ack, smp_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [2:0]  e_ack, e_rv, el;
        logic        e_conf, e_sel, e_wr;
        logic [15:0] e_addr, e_wdata;
        int          win;
        ev_t         keep[$];
        ev_t         ev;
        @(negedge clk);
        smp_sel = vram_sel; smp_wr = vram_wr; smp_addr = vram_addr; smp_wdata = vram_wdata;
        smp_rdata = rdata; smp_conf = conflict;
        smp_ack = {bl_ack, b_ack, a_ack};
        smp_rv  = {bl_rv, b_rv, a_rv};
        e_ack = '0; e_rv = '0; e_conf = 1'b0;
        if (!rst_n) begin
            evq.delete();
            m_ptr  = 0;
            m_last = '0;
        end
        foreach (evq[i]) begin
            if (evq[i].due == cyc) begin
                if (evq[i].kind == 0) e_ack[evq[i].port] = 1'b1;
                else if (evq[i].kind == 1) begin
                    e_rv[evq[i].port] = 1'b1;
                    m_last = evq[i].data;
                end else e_conf = 1'b1;
            end else if (evq[i].due > cyc) keep.push_back(evq[i]);
        end
        evq = keep;
        win = -1;
        e_sel = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
        if (rst_n) begin
            if (!blit) begin
                e_sel  = vid_sel;
                e_addr = vid_addr;
            end else begin
                el = req & ~e_ack;
`ifdef VRAM_ARB_HOST_PRIORITY_EN
                if (el[m_ptr]) win = m_ptr;
                else if (el[1-m_ptr]) win = 1 - m_ptr;
                else if (el[2]) win = 2;
                if (win == 0 || win == 1) m_ptr = 1 - win;
`else
                for (int off = 0; off < 3; off++) begin
                    int k;
                    k = (m_ptr + off) % 3;
                    if (win < 0 && el[k]) win = k;
                end
                if (win >= 0) m_ptr = (win + 1) % 3;
`endif
                if (win >= 0) begin
                    e_sel = 1'b1; e_wr = wr[win]; e_addr = addr[win]; e_wdata = wdata[win];
                    ev = '{cyc + 1, 0, win, 16'h0000};
                    evq.push_back(ev);
                    if (!wr[win]) begin
                        ev = '{cyc + 2, 1, win, bram_f(addr[win])};
                        evq.push_back(ev);
                    end
                end
                if (vid_sel) begin
                    ev = '{cyc + 1, 2, 0, 16'h0000};
                    evq.push_back(ev);
                end
            end
        end
        chk("vram_sel", 32'(smp_sel), 32'(e_sel));
        chk("vram_wr", 32'(smp_wr), 32'(e_wr));
        if (e_sel || !rst_n) chk("vram_addr", 32'(smp_addr), 32'(e_addr));
        if ((e_sel && e_wr) || !rst_n) chk("vram_wdata", 32'(smp_wdata), 32'(e_wdata));
        chk("ack", 32'(smp_ack), 32'(e_ack));
        chk("rvalid", 32'(smp_rv), 32'(e_rv));
        chk("vid_conflict", 32'(smp_conf), 32'(e_conf));
        if ((|e_rv) || !rst_n) chk("rdata", 32'(smp_rdata), 32'(m_last));
        m_ack = e_ack;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_req(input int k);
        req[k]   = 1'b1;
        wr[k]    = 1'($urandom_range(0, 1));
        addr[k]  = 16'($urandom);
        wdata[k] = 16'($urandom);
    endtask

    typedef struct {
        bit          blit;
        bit          vsel;
        logic [15:0] vaddr;
        bit          areq;
        bit          exp_sel;
        bit          chk_addr;
        logic [15:0] exp_addr;
        bit          exp_conf;
    } vec_t;

    vec_t vecs[8];
    int   got_order[6];
    int   exp_order[6];

    initial begin
        for (int k = 0; k < 3; k++) begin
            addr[k]  = '0;
            wdata[k] = '0;
        end
`ifdef VRAM_ARB_HOST_PRIORITY_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        vecs[0] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'hABCD, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 16'h0042, 1'b0, 1'b1, 1'b1, 16'h0042, 1'b0};

        // reset with every port requesting, then 3-way contention
        blit = 1'b1; req = 3'b111; wr = 3'b000;
        addr[0] = 16'h0010; addr[1] = 16'h0020; addr[2] = 16'h0030;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vram_sel", 32'(smp_sel), 32'd0);
            chk("rst_acks", 32'(smp_ack), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) chk("first_grant_addr", 32'(smp_addr), 32'h0010);
            if (i > 0) got_order[i-1] = smp_ack[0] ? 0 : smp_ack[1] ? 1 : smp_ack[2] ? 2 : -1;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        req = 3'b000;
        repeat (3) tick();

        // video pass-through, request dropped before a blit slot, conflict pulse
        addr[0] = 16'h0077; wr[0] = 1'b0;
        foreach (vecs[i]) begin
            blit = vecs[i].blit; vid_sel = vecs[i].vsel; vid_addr = vecs[i].vaddr;
            req[0] = vecs[i].areq;
            tick();
            chk($sformatf("vec%0d_sel", i), 32'(smp_sel), 32'(vecs[i].exp_sel));
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), 32'(smp_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_wr", i), 32'(smp_wr), 32'd0);
            chk($sformatf("vec%0d_a_ack", i), 32'(smp_ack[0]), 32'd0);
            chk($sformatf("vec%0d_conflict", i), 32'(smp_conf), 32'(vecs[i].exp_conf));
        end
        vid_sel = 1'b0;

        // single read by A returning BEEF
        blit = 1'b1; req = 3'b001; wr = 3'b000; addr[0] = 16'h0040;
        tick();
        chk("rd_addr_N", 32'(smp_addr), 32'h0040);
        tick();
        chk("rd_ack_N1", 32'(smp_ack), 32'b001);
        req = 3'b000;
        tick();
        chk("rd_rvalid_N2", 32'(smp_rv), 32'b001);
        chk("rd_data_N2", 32'(smp_rdata), 32'hBEEF);

        // blitter write across alternating 2-cycle video/blit pairs
        req = 3'b100; wr[2] = 1'b1; addr[2] = 16'hFFFF; wdata[2] = 16'h5A5A;
        blit = 1'b0; tick(); chk("wr_video0", 32'(smp_wr), 32'd0);
        blit = 1'b0; tick(); chk("wr_video1", 32'(smp_wr), 32'd0);
        blit = 1'b1; tick();
        chk("wr_issue", 32'({smp_sel, smp_wr}), 32'b11);
        chk("wr_addr", 32'(smp_addr), 32'hFFFF);
        chk("wr_wdata", 32'(smp_wdata), 32'h5A5A);
        blit = 1'b1; tick(); chk("wr_ack", 32'(smp_ack), 32'b100);
        req = 3'b000;
        blit = 1'b0; tick(); chk("wr_no_rvalid0", 32'(smp_rv), 32'd0);
        blit = 1'b0; tick(); chk("wr_no_rvalid1", 32'(smp_rv), 32'd0);

        // reset in the middle of a read
        blit = 1'b1; req = 3'b001; wr = 3'b000; addr[0] = 16'h0100;
        tick();
        rst_n = 1'b0; req = 3'b000;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_replay_rvalid", 32'(smp_rv), 32'd0);
            chk("no_replay_ack", 32'(smp_ack), 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            blit     = ($urandom_range(0, 3) != 0);
            vid_sel  = ($urandom_range(0, 7) == 0);
            vid_addr = 16'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (req[k]) begin
                    if (m_ack[k]) begin
                        if ($urandom_range(0, 1) == 1) new_req(k);
                        else req[k] = 1'b0;
                    end else if ($urandom_range(0, 31) == 0) req[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) new_req(k);
            end
            tick();
        end
        req = 3'b000;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
